// File: rtl/bus_arbiter_mux.sv
// Registered bus arbiter and multiplexer: fixed-priority or round-robin selection
// among NSRC sources, bounded locked bursts, and a saturating contention counter.
module bus_arbiter_mux #(
    parameter int WIDTH     = 32,
    parameter int NSRC      = 24,
    parameter int ARB_MODE  = 0,
    parameter int MAX_BURST = 4,
    parameter int IDLE_ZERO = 0,
    parameter int SW        = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NSRC-1:0]       src_req,
    input  logic [NSRC-1:0]       src_lock,
    input  logic [NSRC*WIDTH-1:0] src_data,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  bus_valid,
    output logic [SW-1:0]         bus_owner,
    output logic [NSRC-1:0]       src_gnt,
    output logic [15:0]           contention_cnt,
    output logic                  burst_active,
    output logic [0:0]            dbg_state
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    // Handshake: src_req is a one-cycle request qualified by the word on src_data at
    // the same edge; src_gnt/bus_valid one cycle later report that the word was taken.
    // There is no back-pressure: consumers must accept every valid bus word.

    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             bus_valid_q, bus_valid_d;
    logic [SW-1:0]    bus_owner_q, bus_owner_d;
    logic [NSRC-1:0]  src_gnt_q, src_gnt_d;
    logic [15:0]      cont_cnt_q, cont_cnt_d;
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [0:0]       state_q, state_d;

    logic [NSRC-1:0]  owner_oh;
    logic [NSRC-1:0]  others;
    logic [NSRC-1:0]  cand;
    logic             hold;
    logic             found;
    logic [SW-1:0]    pick;
    logic [SW-1:0]    rr_idx;
    logic             win_valid;
    logic [SW-1:0]    win;

    always_comb begin
        owner_oh              = '0;
        owner_oh[bus_owner_q] = 1'b1;
        hold = (state_q == ST_LOCKED) && src_req[bus_owner_q] && src_lock[bus_owner_q] &&
               (burst_cnt_q < BW'(MAX_BURST));
        // A released owner stands aside only when someone else is asking.
        others = src_req & ~owner_oh;
        cand   = ((state_q == ST_LOCKED) && (others != '0)) ? others : src_req;

        found  = 1'b0;
        pick   = '0;
        rr_idx = '0;
        if (ARB_MODE == 0) begin
            for (int i = NSRC - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    pick  = SW'(i);
                end
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                rr_idx = SW'((int'(rr_ptr_q) + i) % NSRC);
                if (!found && cand[rr_idx]) begin
                    found = 1'b1;
                    pick  = rr_idx;
                end
            end
        end

        win_valid = hold | found;
        win       = hold ? bus_owner_q : pick;
    end

    always_comb begin
        bus_data_d  = bus_data_q;
        bus_valid_d = bus_valid_q;
        bus_owner_d = bus_owner_q;
        src_gnt_d   = src_gnt_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        state_d     = state_q;
        cont_cnt_d  = cont_cnt_q;

        if (win_valid) begin
            for (int i = 0; i < NSRC; i++) begin
                if (win == SW'(i)) begin
                    bus_data_d = src_data[i*WIDTH +: WIDTH];
                end
            end
            bus_valid_d    = 1'b1;
            bus_owner_d    = win;
            src_gnt_d      = '0;
            src_gnt_d[win] = 1'b1;
            if (hold) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
                if (ARB_MODE != 0) begin
                    rr_ptr_d = (win == SW'(NSRC - 1)) ? '0 : win + 1'b1;
                end
                if (src_lock[win] && (MAX_BURST > 1)) begin
                    state_d     = ST_LOCKED;
                    burst_cnt_d = BW'(1);
                end else begin
                    state_d     = ST_IDLE;
                    burst_cnt_d = '0;
                end
            end
        end else begin
            bus_valid_d = 1'b0;
            src_gnt_d   = '0;
            if (IDLE_ZERO != 0) begin
                bus_data_d = '0;
            end
            state_d     = ST_IDLE;
            burst_cnt_d = '0;
        end

        if (($countones(src_req) >= 2) && (cont_cnt_q != 16'hFFFF)) begin
            cont_cnt_d = cont_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_data_q  <= '0;
            bus_valid_q <= 1'b0;
            bus_owner_q <= '0;
            src_gnt_q   <= '0;
            cont_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            state_q     <= ST_IDLE;
        end else begin
            bus_data_q  <= bus_data_d;
            bus_valid_q <= bus_valid_d;
            bus_owner_q <= bus_owner_d;
            src_gnt_q   <= src_gnt_d;
            cont_cnt_q  <= cont_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            state_q     <= state_d;
        end
    end

    assign bus_data       = bus_data_q;
    assign bus_valid      = bus_valid_q;
    assign bus_owner      = bus_owner_q;
    assign src_gnt        = src_gnt_q;
    assign contention_cnt = cont_cnt_q;
    assign burst_active   = (state_q == ST_LOCKED);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: fixed-priority, round-robin and idle-zero instances share one
// stimulus stream; expectations are hand-computed constants and an owner queue.
module tb_bus_arbiter_mux;

    localparam int W  = 32;
    localparam int N  = 24;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   src_req;
    logic [N-1:0]   src_lock;
    logic [N*W-1:0] src_data;

    logic [W-1:0]  fp_data,  rr_data,  iz_data;
    logic          fp_valid, rr_valid, iz_valid;
    logic [SW-1:0] fp_owner, rr_owner, iz_owner;
    logic [N-1:0]  fp_gnt,   rr_gnt,   iz_gnt;
    logic [15:0]   fp_cnt,   rr_cnt,   iz_cnt;
    logic          fp_burst, rr_burst, iz_burst;
    logic [0:0]    fp_st,    rr_st,    iz_st;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(0), .MAX_BURST(4), .IDLE_ZERO(0)) u_fp (
        .clk(clk), .clr(clr), .src_req(src_req), .src_lock(src_lock), .src_data(src_data),
        .bus_data(fp_data), .bus_valid(fp_valid), .bus_owner(fp_owner), .src_gnt(fp_gnt),
        .contention_cnt(fp_cnt), .burst_active(fp_burst), .dbg_state(fp_st));

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(1), .MAX_BURST(4), .IDLE_ZERO(0)) u_rr (
        .clk(clk), .clr(clr), .src_req(src_req), .src_lock(src_lock), .src_data(src_data),
        .bus_data(rr_data), .bus_valid(rr_valid), .bus_owner(rr_owner), .src_gnt(rr_gnt),
        .contention_cnt(rr_cnt), .burst_active(rr_burst), .dbg_state(rr_st));

    bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(0), .MAX_BURST(4), .IDLE_ZERO(1)) u_iz (
        .clk(clk), .clr(clr), .src_req(src_req), .src_lock(src_lock), .src_data(src_data),
        .bus_data(iz_data), .bus_valid(iz_valid), .bus_owner(iz_owner), .src_gnt(iz_gnt),
        .contention_cnt(iz_cnt), .burst_active(iz_burst), .dbg_state(iz_st));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse clr between edges so no edge is consumed.
    task automatic pulse_reset();
        clr = 1'b1;
        #1;
        clr = 1'b0;
    endtask

    function automatic logic [31:0] oh(input int i);
        logic [31:0] v;
        v = 32'd1 << i;
        return v;
    endfunction

    initial begin
        clr      = 1'b1;
        src_req  = '1;
        src_lock = '0;
        for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hA000_0000 | i;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, fp_valid}, 32'd0);
        check("rst_gnt",   {8'd0, fp_gnt},    32'd0);
        check("rst_cnt",   {16'd0, fp_cnt},   32'd0);
        check("rst_owner", {27'd0, fp_owner}, 32'd0);
        check("rst_data",  fp_data,           32'd0);
        check("rst_burst", {31'd0, rr_burst}, 32'd0);

        // first grant after reset, req {3,7}
        src_req = '0;
        src_req[3] = 1'b1;
        src_req[7] = 1'b1;
        clr = 1'b0;
        step();
        check("first_owner", {27'd0, fp_owner}, 32'd3);
        check("first_data",  fp_data,           32'hA000_0003);
        check("first_gnt",   {8'd0, fp_gnt},    oh(3));
        check("first_valid", {31'd0, fp_valid}, 32'd1);
        check("first_rr",    {27'd0, rr_owner}, 32'd3);

        // fixed priority, req = 0x000081 for 3 cycles; rr alternates 0,7,0
        pulse_reset();
        src_req = 24'h000081;
        for (int c = 0; c < 3; c++) begin
            step();
            check("fp_owner", {27'd0, fp_owner}, 32'd0);
            check("fp_rr_owner", {27'd0, rr_owner}, (c == 1) ? 32'd7 : 32'd0);
        end
        check("fp_cnt3", {16'd0, fp_cnt}, 32'd3);

        // round-robin wrap with everyone requesting
        pulse_reset();
        src_req = '1;
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        while (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            step();
            check("rr_owner", {27'd0, rr_owner}, e);
            check("rr_gnt",   {8'd0, rr_gnt},    oh(int'(e)));
        end

        // burst: 5 locks, 2 plain
        pulse_reset();
        src_req = '0;
        src_req[2] = 1'b1;
        src_req[5] = 1'b1;
        src_lock = '0;
        src_lock[5] = 1'b1;
        exp_q = {32'd2, 32'd5, 32'd5, 32'd5, 32'd5, 32'd2};
        for (int c = 0; c < 6; c++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            step();
            check("burst_rr_owner", {27'd0, rr_owner}, e);
            check("burst_rr_active", {31'd0, rr_burst}, (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            check("burst_fp_owner", {27'd0, fp_owner}, 32'd2);
            check("burst_fp_active", {31'd0, fp_burst}, 32'd0);
        end
        step();
        check("burst_rr_relock", {27'd0, rr_owner}, 32'd5);
        check("burst_rr_relock_act", {31'd0, rr_burst}, 32'd1);

        // asynchronous clear in the middle of a burst
        #2;
        clr = 1'b1;
        #1;
        check("async_valid", {31'd0, rr_valid}, 32'd0);
        check("async_gnt",   {8'd0, rr_gnt},    32'd0);
        check("async_cnt",   {16'd0, rr_cnt},   32'd0);
        check("async_burst", {31'd0, rr_burst}, 32'd0);
        step();
        clr = 1'b0;
        step();
        check("post_clr_rr_owner", {27'd0, rr_owner}, 32'd2);

        // sole locked requester: re-granted with no gap in burst_active
        pulse_reset();
        src_req = '0;
        src_req[5] = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            check("sole_owner", {27'd0, fp_owner}, 32'd5);
            check("sole_active", {31'd0, fp_burst}, 32'd1);
            check("sole_rr_active", {31'd0, rr_burst}, 32'd1);
        end

        // idle behaviour
        pulse_reset();
        src_lock = '0;
        src_data[1*W +: W] = 32'hDEAD_BEEF;
        src_req = '0;
        src_req[1] = 1'b1;
        step();
        check("idle_grant_data", iz_data, 32'hDEAD_BEEF);
        src_req = '0;
        step();
        check("iz_valid", {31'd0, iz_valid}, 32'd0);
        check("iz_data",  iz_data,           32'd0);
        check("iz_owner", {27'd0, iz_owner}, 32'd1);
        check("hold_data", fp_data,          32'hDEAD_BEEF);
        check("hold_gnt", {8'd0, fp_gnt},    32'd0);
        check("hold_burst", {31'd0, fp_burst}, 32'd0);

        // saturation
        pulse_reset();
        src_req = '1;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_cnt", {16'd0, fp_cnt}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
